mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_responder.sv | 125 ++++++++++++
 tb/tb_mem_responder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: access widths, FSM states and
// the byte-address mask that defines the 16 KiB wrap-around window.
package mem_pkg;
  localparam logic [1:0] W_WORD = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_BYTE = 2'd2;
  localparam logic [1:0] W_RSVD = 2'd3;

  localparam logic [31:0] ADDR_MASK = 32'h0000_3FFF;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: alignment check, byte enables, store merge and
// extended load extraction for one 32-bit memory word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  width,
  input  logic        sign,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        err,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] ldata
);
  logic [31:0]       wrep;
  logic [31:0]       shifted;
  logic signed [7:0]  lb;
  logic signed [15:0] lh;

  always_comb begin
    err = (width == W_RSVD) ||
          ((width == W_HALF) && lo[0]) ||
          ((width == W_WORD) && (lo != 2'b00));

    be   = 4'b0000;
    wrep = wdata;
    case (width)
      W_WORD: be = 4'b1111;
      W_HALF: begin
        be   = lo[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata[15:0]}};
      end
      W_BYTE: begin
        be   = 4'b0001 << lo;
        wrep = {4{wdata[7:0]}};
      end
      default: be = 4'b0000;
    endcase

    for (int i = 0; i < 4; i++) begin
      wword[8*i +: 8] = be[i] ? wrep[8*i +: 8] : rword[8*i +: 8];
    end

    shifted = rword >> {lo, 3'b000};
    lb      = signed'(shifted[7:0]);
    lh      = signed'(shifted[15:0]);
    ldata   = rword;
    case (width)
      W_HALF:  ldata = sign ? 32'(lh) : {16'h0000, shifted[15:0]};
      W_BYTE:  ldata = sign ? 32'(lb) : {24'h000000, shifted[7:0]};
      default: ldata = rword;
    endcase
    if (err) ldata = '0;
  end
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with power-up clear and fixed latency.
// Optional store trace enabled by defining MEM_RESP_TRACE_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_width,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  state_t            state, state_nx;
  logic              accept, xfer;
  logic [IDX_W-1:0]  clr_idx;
  logic [3:0]        cnt;

  logic              we_p0, sign_p0;
  logic [1:0]        width_p0;
  logic [31:0]       addr_p0, wdata_p0, pc_p0;
  logic [IDX_W-1:0]  idx_p0;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              err;
  logic [3:0]        be;
  logic [31:0]       wword, ldata;

  assign idx_p0 = addr_p0[IDX_W+1:2];

  mem_lane_align u_align (
    .width (width_p0),
    .sign  (sign_p0),
    .lo    (addr_p0[1:0]),
    .wdata (wdata_p0),
    .rword (mem[idx_p0]),
    .err   (err),
    .be    (be),
    .wword (wword),
    .ldata (ldata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= CLEAR;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    xfer      = 1'b0;
    case (state)
      CLEAR: if (clr_idx == LAST_IDX) state_nx = IDLE;
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: if (cnt == 4'd0) begin
        xfer     = 1'b1;
        state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_idx   <= '0;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == CLEAR) clr_idx <= (clr_idx == LAST_IDX) ? '0 : clr_idx + 1'b1;
      if (accept)                          cnt <= 4'(LATENCY);
      else if (state == WAIT && cnt != 0)  cnt <= cnt - 1'b1;
      if (xfer) begin
        rsp_err   <= err;
        rsp_rdata <= (we_p0 || err) ? '0 : ldata;
      end
    end
  end

  // Request capture (stage p0) and the storage array; neither is reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      width_p0 <= req_width;
      sign_p0  <= req_sign;
      addr_p0  <= req_addr & ADDR_MASK;
      wdata_p0 <= req_wdata;
      pc_p0    <= req_pc;
    end
    if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (xfer && we_p0 && !err) begin
      mem[idx_p0] <= wword;
`ifdef MEM_RESP_TRACE_EN
      $display("@%h: *%h <= %h", pc_p0, {addr_p0[31:2], 2'b00}, wword);
`endif
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: clear timing, lane merge/extract,
// error handling, backpressure, address wrap and reset mid-transaction.
module tb_mem_responder;
  localparam int DEPTH   = 4096;
  localparam int LAT     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_sign;
  logic [1:0]  req_width;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_width (req_width),
    .req_sign  (req_sign),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (!req_ready && n < 3 * DEPTH) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_clear_cycles"}, 64'(n), 64'(DEPTH));
  endtask

  task automatic issue(input string tag, input logic we, input logic [1:0] w,
                       input logic s, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err, input int hold);
    int n;
    exp_t e;
    logic [31:0] rd0;
    logic er0;
    n = 0;
    while (!req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_width = w; req_sign = s;
    req_addr = a; req_wdata = d; req_pc = 32'h0000_1000 + a;
    sb.push_back('{rdata: exp_rd, err: exp_err});
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(LAT + 1));
    rd0 = rsp_rdata;
    er0 = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_stable"}, {31'd0, rsp_valid, er0, rd0}, {31'd0, 1'b1, rsp_err, rsp_rdata});
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
      check({tag, "_err"}, 64'(rsp_err), 64'(e.err));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_done"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_width = 2'd0; req_sign = 1'b0;
    req_addr = '0; req_wdata = '0; req_pc = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata}, '0);
    reset = 1'b1;
    wait_clear("init");

    issue("ld_init",     1'b0, 2'd0, 1'b0, 32'h0000_1234, 32'h0,         32'h0,         1'b0, 0);
    issue("st_word",     1'b1, 2'd0, 1'b0, 32'h0000_0010, 32'hDEADBEEF,  32'h0,         1'b0, 0);
    issue("ld_byte_s",   1'b0, 2'd2, 1'b1, 32'h0000_0013, 32'h0,         32'hFFFFFFDE,  1'b0, 0);
    issue("ld_byte_u",   1'b0, 2'd2, 1'b0, 32'h0000_0013, 32'h0,         32'h000000DE,  1'b0, 0);
    issue("st_half",     1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'hFFFF1234,  32'h0,         1'b0, 0);
    issue("ld_merged",   1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'h0,         32'h1234BEEF,  1'b0, 0);
    issue("st_half_mis", 1'b1, 2'd1, 1'b0, 32'h0000_0011, 32'h0000AAAA,  32'h0,         1'b1, 0);
    issue("ld_unchg",    1'b0, 2'd0, 1'b1, 32'h0000_0010, 32'h0,         32'h1234BEEF,  1'b0, 0);
    issue("ld_rsvd",     1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 0);
    issue("ld_word_mis", 1'b0, 2'd0, 1'b0, 32'h0000_0012, 32'h0,         32'h0,         1'b1, 0);
    issue("st_wrap",     1'b1, 2'd0, 1'b0, 32'h0000_4010, 32'hCAFEF00D,  32'h0,         1'b0, 5);
    issue("ld_wrap",     1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'h0,         32'hCAFEF00D,  1'b0, 0);
    issue("ld_half_s",   1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'h0,         32'hFFFFF00D,  1'b0, 0);
    issue("st_byte",     1'b1, 2'd2, 1'b0, 32'h0000_0011, 32'h00000077,  32'h0,         1'b0, 0);
    issue("ld_bytemrg",  1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'h0,         32'hCAFE770D,  1'b0, 2);
    issue("ld_hi_half",  1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0,         32'h0000CAFE,  1'b0, 0);

    // store to 0x20 interrupted by reset while waiting
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_width = 2'd0; req_sign = 1'b0;
    req_addr = 32'h0000_0020; req_wdata = 32'h55AA55AA; req_pc = 32'h0000_2000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_mid_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_clear("restart");
    issue("ld_dropped",  1'b0, 2'd0, 1'b0, 32'h0000_0020, 32'h0,         32'h0,         1'b0, 0);
    issue("ld_recleared",1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
